keypad_scan_encoder: RTL and testbench
======================================

Name: keypad_scan_encoder

Overview:
- Scans a 4x3 matrix keypad (1-9, *, 0, #), debounces it and emits one single-cycle pulse per accepted press.
- Produces the digit, confirm and clear strobes consumed by the password-entry/display state machine.
- Outputs are already registered, clean, one-hot per press, so the consumer needs no edge detection.

Parameters:
- SCAN_DIV, 1000: clk cycles each row is driven; range 2..65535.
- DEB_SCANS, 4: consecutive identical full frames required to accept a press or a release; range 1..15.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- row  output  4  keypad row drive, active-low, one-cold (row0 = 1-2-3, row1 = 4-5-6, row2 = 7-8-9, row3 = *-0-#).
- col  input  3  keypad column sense, active-low (pulled up externally); col0 = left column. Asynchronous to clk.
- digit  output  10  one-cycle pulse; bit n = digit n accepted.
- ok  output  1  one-cycle pulse; '#' accepted.
- clr  output  1  one-cycle pulse; '*' accepted.
- key_code  output  4  last accepted key: 0-9 digits, 4'hA = '*', 4'hB = '#', 4'hF = none since reset.
- key_held  output  1  high from the accept pulse until the release is accepted.

Behaviour:
- Reset (reset==0 at posedge clk):
  - row = 4'b1110.
  - Slot counter and row index = 0; frame snapshot cleared.
  - FSM = IDLE; debounce count = 0.
  - digit, ok, clr = 0; key_held = 0; key_code = 4'hF.
- Input sync: col passes through a 2-flop synchronizer before use.
- Scan:
  - Slot counter runs 0..SCAN_DIV-1 per row.
  - At count SCAN_DIV-1 the synchronized col is sampled into 3 bits of a 12-bit frame snapshot (bit = 1 means pressed). The row index then advances and wraps 3 to 0; row updates on the same edge.
  - Frame = 4*SCAN_DIV cycles. The frame is evaluated in the cycle after the row3 sample; scanning continues without a gap.
- Frame classification: NONE (0 bits set), SINGLE(k) (exactly 1 bit set), MULTI (2 or more bits set).
- FSM, evaluated once per frame:
  - IDLE:
    - SINGLE(k): candidate = k, count = 1, go to DEB (if DEB_SCANS==1, accept immediately).
    - Otherwise stay.
  - DEB:
    - SINGLE(candidate): count+1; when count reaches DEB_SCANS, accept and go to HELD.
    - SINGLE(other key): candidate = new key, count = 1.
    - NONE or MULTI: go to IDLE, count = 0.
  - HELD:
    - NONE: count = 1, go to REL (if DEB_SCANS==1, go to IDLE).
    - Any key(s): stay. No repeat; another key never produces a pulse here.
  - REL:
    - NONE: count+1; at DEB_SCANS go to IDLE and drop key_held.
    - Any key: return to HELD.
- Accept:
  - In the cycle after the accepting evaluation, exactly one of digit[n], ok or clr is high for exactly one clk.
  - key_code updates on the same edge and holds until the next accept.
  - key_held rises on the same edge.
- Latency: with a clean press, the pulse comes 1 cycle after the end of the DEB_SCANS-th consecutive SINGLE frame. It is never more than one per physical press.
- Boundaries:
  - A key pressed or released mid-frame just yields that frame's sampled value.
  - Reset mid-debounce or mid-HELD aborts with no pulse. A key still held after reset is treated as a new press, with full debounce.
- At most one pulse output is high in any cycle.

Test Plan (SCAN_DIV=4, DEB_SCANS=3, frame = 16 cycles):
1. Reset held 3 cycles, then released:
   - row==4'b1110; digit==0, ok==0, clr==0; key_code==4'hF; key_held==0.
   - row steps 1110 -> 1101 -> 1011 -> 0111 every 4 cycles and wraps.
2. Hold '5' (col1 low while row1 low) for 6 frames, then release for 4 frames:
   - Exactly one digit==10'b0000100000 pulse, 1 cycle after the end of frame 3.
   - key_code==5; key_held high until the end of release frame 3, then low. No second pulse.
3. Bounce on '7': present 2 frames, absent 1, present 3:
   - Single digit[7] pulse, only after the 3rd frame following the gap.
4. '1' and '3' held together for 10 frames:
   - No pulse; key_code unchanged; key_held==0.
5. '#', '*' and '0' pressed in turn (each held 4 frames, released 4 frames):
   - ok pulse with key_code==4'hB; then clr pulse with code 4'hA; then digit[0] pulse with code 0.
6. '9' held; reset asserted during its 2nd frame, deasserted, '9' still held:
   - No pulse during or immediately after reset.
   - Pulse exactly once after 3 full frames post-reset.
   - '2' pressed while '9' is still held (HELD): no pulse.

Source files
------------

// File: rtl/keypad_scan_encoder_if.sv
// Keypad-side and consumer-side signals of the keypad scan encoder.
// The encoder side is master; the bench or keypad model is slave.
interface keypad_scan_encoder_if;
  logic [3:0] row;
  logic [2:0] col;
  logic [9:0] digit;
  logic       ok;
  logic       clr;
  logic [3:0] key_code;
  logic       key_held;

  modport master (output row, digit, ok, clr, key_code, key_held, input col);
  modport slave  (input row, digit, ok, clr, key_code, key_held, output col);
endinterface

// File: rtl/keypad_scan_encoder.sv
// 4x3 matrix keypad scanner with frame-level debounce.
// Emits one registered strobe per accepted press.
module keypad_scan_encoder #(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned DEB_SCANS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  keypad_scan_encoder_if.master kp
);

  localparam int unsigned SLOT_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned KEYS   = 12;

  typedef enum logic [1:0] {IDLE, DEB, HELD, REL} state_e;

  logic [2:0]        col_s1_q, col_s2_q;
  logic [SLOT_W-1:0] slot_q;
  logic [1:0]        ridx_q;
  logic [3:0]        row_q;
  logic [KEYS-1:0]   frame_q;
  logic              eval_q;
  logic              slot_last;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [3:0]        cand_q, cand_d;
  logic [9:0]        digit_q, digit_d;
  logic              ok_q, ok_d, clr_q, clr_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              held_q, held_d;

  logic [3:0]        n_set;
  logic [3:0]        hit_idx;
  logic              f_none, f_single;

  // Frame bit index (row*3 + col) to key code.
  function automatic logic [3:0] code_of(input logic [3:0] idx);
    case (idx)
      4'd9:    code_of = 4'hA;
      4'd10:   code_of = 4'h0;
      4'd11:   code_of = 4'hB;
      default: code_of = idx + 4'd1;
    endcase
  endfunction

  assign slot_last = (slot_q == SLOT_W'(SCAN_DIV - 1));

  // Column synchronizer, row scan and frame snapshot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      col_s1_q <= 3'b111;
      col_s2_q <= 3'b111;
      slot_q   <= '0;
      ridx_q   <= '0;
      row_q    <= 4'b1110;
      frame_q  <= '0;
      eval_q   <= 1'b0;
    end else begin
      col_s1_q <= kp.col;
      col_s2_q <= col_s1_q;
      eval_q   <= 1'b0;
      if (slot_last) begin
        slot_q <= '0;
        case (ridx_q)
          2'd0: frame_q[2:0]  <= ~col_s2_q;
          2'd1: frame_q[5:3]  <= ~col_s2_q;
          2'd2: frame_q[8:6]  <= ~col_s2_q;
          2'd3: frame_q[11:9] <= ~col_s2_q;
          default: ;
        endcase
        ridx_q <= ridx_q + 2'd1;
        row_q  <= {row_q[2:0], row_q[3]};
        eval_q <= (ridx_q == 2'd3);
      end else begin
        slot_q <= slot_q + SLOT_W'(1);
      end
    end
  end

  // Count pressed keys in the frame and remember the highest one.
  always_comb begin
    n_set   = '0;
    hit_idx = '0;
    for (int i = 0; i < KEYS; i++) begin
      if (frame_q[i]) begin
        n_set   = n_set + 4'd1;
        hit_idx = 4'(i);
      end
    end
  end

  assign f_none   = (n_set == 4'd0);
  assign f_single = (n_set == 4'd1);
  assign cnt_inc  = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cand_q     <= '0;
      digit_q    <= '0;
      ok_q       <= 1'b0;
      clr_q      <= 1'b0;
      key_code_q <= 4'hF;
      held_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      digit_q    <= digit_d;
      ok_q       <= ok_d;
      clr_q      <= clr_d;
      key_code_q <= key_code_d;
      held_q     <= held_d;
    end
  end

  // Debounce FSM, stepped once per completed frame; strobes default low.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    digit_d    = '0;
    ok_d       = 1'b0;
    clr_d      = 1'b0;
    key_code_d = key_code_q;
    held_d     = held_q;

    if (eval_q) begin
      case (state_q)
        IDLE: begin
          if (f_single) begin
            cand_d = hit_idx;
            cnt_d  = CNT_W'(1);
            if (DEB_SCANS == 1) begin
              state_d = HELD;
              held_d  = 1'b1;
            end else begin
              state_d = DEB;
            end
          end
        end
        DEB: begin
          if (f_single && (hit_idx == cand_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(DEB_SCANS)) begin
              state_d = HELD;
              held_d  = 1'b1;
            end
          end else if (f_single) begin
            cand_d = hit_idx;
            cnt_d  = CNT_W'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HELD: begin
          if (f_none) begin
            cnt_d = CNT_W'(1);
            if (DEB_SCANS == 1) begin
              state_d = IDLE;
              cnt_d   = '0;
              held_d  = 1'b0;
            end else begin
              state_d = REL;
            end
          end
        end
        REL: begin
          if (f_none) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(DEB_SCANS)) begin
              state_d = IDLE;
              cnt_d   = '0;
              held_d  = 1'b0;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Rising key_held marks the accepting evaluation.
    if (held_d && !held_q) begin
      key_code_d = code_of(cand_d);
      case (key_code_d)
        4'hA:    clr_d   = 1'b1;
        4'hB:    ok_d    = 1'b1;
        default: digit_d = 10'(1) << key_code_d;
      endcase
    end
  end

  assign kp.row      = row_q;
  assign kp.digit    = digit_q;
  assign kp.ok       = ok_q;
  assign kp.clr      = clr_q;
  assign kp.key_code = key_code_q;
  assign kp.key_held = held_q;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Directed bench for keypad_scan_encoder: behavioural keypad matrix,
// frame-aligned stimulus and hand-computed expected strobes.
module tb_keypad_scan_encoder;

  localparam int unsigned SCAN_DIV  = 4;
  localparam int unsigned DEB_SCANS = 3;
  localparam int          FRAME     = 16;

  // Frame bit index = row*3 + col
  localparam logic [11:0] K1 = 12'(1) << 0;
  localparam logic [11:0] K2 = 12'(1) << 1;
  localparam logic [11:0] K3 = 12'(1) << 2;
  localparam logic [11:0] K5 = 12'(1) << 4;
  localparam logic [11:0] K7 = 12'(1) << 6;
  localparam logic [11:0] K9 = 12'(1) << 8;
  localparam logic [11:0] KS = 12'(1) << 9;
  localparam logic [11:0] K0 = 12'(1) << 10;
  localparam logic [11:0] KH = 12'(1) << 11;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] pressed;

  keypad_scan_encoder_if kp_if ();

  keypad_scan_encoder #(
    .SCAN_DIV (SCAN_DIV),
    .DEB_SCANS(DEB_SCANS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .kp   (kp_if)
  );

  always #5 clk = ~clk;

  // Pressed key shorts its row line to its column line.
  always_comb begin
    kp_if.col = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && !kp_if.row[r]) kp_if.col[c] = 1'b0;
  end

  int          checks = 0;
  int          errors = 0;
  int          pulse_cnt = 0;
  int          multi_cnt = 0;
  int          frame_no = 0;
  int          last_frame = -1;
  int          last_j = -1;
  logic [11:0] last_vec = '0;
  logic        held_start [128];
  logic        held_end   [128];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Record strobes and key_held at one negedge; j is the cycle within the frame.
  task sample(input int j);
    logic [11:0] vec;
    vec = {kp_if.digit, kp_if.ok, kp_if.clr};
    if (vec != 12'd0) begin
      pulse_cnt++;
      last_frame = frame_no;
      last_j     = j;
      last_vec   = vec;
      if ($countones(vec) > 1) multi_cnt++;
    end
    if (frame_no < 128) begin
      if (j == 0)         held_start[frame_no] = kp_if.key_held;
      if (j == FRAME - 1) held_end[frame_no]   = kp_if.key_held;
    end
  endtask

  // Called at a negedge just before a frame starts.
  task run_frames(input logic [11:0] keys, input int n);
    for (int f = 0; f < n; f++) begin
      pressed = keys;
      for (int j = 0; j < FRAME; j++) begin
        @(negedge clk);
        sample(j);
      end
      frame_no++;
    end
  endtask

  // Called at a negedge; three reset edges, returns just before the first free edge.
  task apply_reset();
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      sample(-1);
    end
    reset    = 1'b1;
    frame_no = 0;
  endtask

  task check_reset_state(input string tag);
    check_eq({tag, "_row"},   32'(kp_if.row), 32'h0000_000E);
    check_eq({tag, "_pulse"}, 32'({kp_if.digit, kp_if.ok, kp_if.clr}), 32'd0);
    check_eq({tag, "_code"},  32'(kp_if.key_code), 32'h0000_000F);
    check_eq({tag, "_held"},  32'(kp_if.key_held), 32'd0);
  endtask

  initial begin
    logic [11:0] seq_keys  [3];
    logic [11:0] seq_vec   [3];
    logic [3:0]  seq_code  [3];
    int          f0;
    int          pc0;

    pressed = '0;
    reset   = 1'b0;

    // 1: reset values and row rotation
    @(negedge clk);
    apply_reset();
    check_reset_state("rst");
    pressed = '0;
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      sample(j);
      if (j == 2)  check_eq("row_j2",  32'(kp_if.row), 32'h0000_000E);
      if (j == 3)  check_eq("row_j3",  32'(kp_if.row), 32'h0000_000D);
      if (j == 7)  check_eq("row_j7",  32'(kp_if.row), 32'h0000_000B);
      if (j == 11) check_eq("row_j11", 32'(kp_if.row), 32'h0000_0007);
      if (j == 15) check_eq("row_wrap", 32'(kp_if.row), 32'h0000_000E);
    end
    frame_no++;

    // 2: '5' held 6 frames, released 4
    f0 = frame_no; pc0 = pulse_cnt;
    run_frames(K5, 6);
    run_frames('0, 4);
    check_eq("k5_count", 32'(pulse_cnt - pc0), 32'd1);
    check_eq("k5_frame", 32'(last_frame), 32'(f0 + 3));
    check_eq("k5_cycle", 32'(last_j), 32'd0);
    check_eq("k5_vec",   32'(last_vec), 32'({10'b0000100000, 2'b00}));
    check_eq("k5_code",  32'(kp_if.key_code), 32'd5);
    check_eq("k5_held_in",  32'(held_end[f0+8]), 32'd1);
    check_eq("k5_held_out", 32'(held_start[f0+9]), 32'd0);

    // 3: bouncing '7'
    f0 = frame_no; pc0 = pulse_cnt;
    run_frames(K7, 2);
    run_frames('0, 1);
    run_frames(K7, 3);
    run_frames('0, 4);
    check_eq("k7_count", 32'(pulse_cnt - pc0), 32'd1);
    check_eq("k7_frame", 32'(last_frame), 32'(f0 + 6));
    check_eq("k7_vec",   32'(last_vec), 32'({10'b0010000000, 2'b00}));
    check_eq("k7_code",  32'(kp_if.key_code), 32'd7);

    // 4: '1' and '3' together
    f0 = frame_no; pc0 = pulse_cnt;
    run_frames(K1 | K3, 10);
    check_eq("multi_count", 32'(pulse_cnt - pc0), 32'd0);
    check_eq("multi_code",  32'(kp_if.key_code), 32'd7);
    check_eq("multi_held",  32'(held_end[f0+9]), 32'd0);
    run_frames('0, 2);

    // 5: '#', '*', '0' in turn
    seq_keys[0] = KH; seq_vec[0] = {10'd0, 2'b10};          seq_code[0] = 4'hB;
    seq_keys[1] = KS; seq_vec[1] = {10'd0, 2'b01};          seq_code[1] = 4'hA;
    seq_keys[2] = K0; seq_vec[2] = {10'b0000000001, 2'b00}; seq_code[2] = 4'h0;
    for (int k = 0; k < 3; k++) begin
      f0 = frame_no; pc0 = pulse_cnt;
      run_frames(seq_keys[k], 4);
      run_frames('0, 4);
      check_eq($sformatf("seq%0d_count", k), 32'(pulse_cnt - pc0), 32'd1);
      check_eq($sformatf("seq%0d_frame", k), 32'(last_frame), 32'(f0 + 3));
      check_eq($sformatf("seq%0d_vec", k),   32'(last_vec), 32'(seq_vec[k]));
      check_eq($sformatf("seq%0d_code", k),  32'(kp_if.key_code), 32'(seq_code[k]));
    end

    // 6: reset in the middle of debouncing '9'
    pc0 = pulse_cnt;
    run_frames(K9, 1);
    pressed = K9;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      sample(j);
    end
    apply_reset();
    check_eq("k9_rst_pulse", 32'(pulse_cnt - pc0), 32'd0);
    check_reset_state("k9_rst");
    run_frames(K9, 4);
    check_eq("k9_count", 32'(pulse_cnt - pc0), 32'd1);
    check_eq("k9_frame", 32'(last_frame), 32'd3);
    check_eq("k9_cycle", 32'(last_j), 32'd0);
    check_eq("k9_vec",   32'(last_vec), 32'({10'b1000000000, 2'b00}));
    check_eq("k9_code",  32'(kp_if.key_code), 32'd9);
    pc0 = pulse_cnt;
    run_frames(K9 | K2, 3);
    check_eq("k2_in_held_count", 32'(pulse_cnt - pc0), 32'd0);
    check_eq("k2_in_held_code",  32'(kp_if.key_code), 32'd9);
    check_eq("k2_in_held_held",  32'(kp_if.key_held), 32'd1);
    run_frames('0, 4);
    check_eq("k9_released", 32'(kp_if.key_held), 32'd0);

    check_eq("one_hot", 32'(multi_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
